// File: rtl/sort_mem_pkg.sv
// sort_mem_pkg: shared definitions for sort_mem_responder.
//   - Response codes RESP_OKAY / RESP_SLVERR.
//   - Read and write FSM state encodings.
//   - LAT_W: width of the programmable latency counters (latency 0..255).
package sort_mem_pkg;

  localparam int RESP_OKAY   = 0;
  localparam int RESP_SLVERR = 1;

  localparam int LAT_W = 8;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_RESP = 2'd2
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_WAIT = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

endpackage

// File: rtl/resp_delay_ctr.sv
// resp_delay_ctr: load/decrement latency counter, one per bus channel.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   load       load load_val this cycle (transaction accepted)
//   load_val   number of wait cycles to count
//   done       high on the last wait cycle (count at 1 or 0)
module resp_delay_ctr
  import sort_mem_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [LAT_W-1:0] load_val,
  output logic             done
);

  logic [LAT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - LAT_W'(1);
    end
  end

  // The FSM leaves its wait state on the edge where the count reads 1, so
  // a load of N yields exactly N wait cycles.
  assign done = (cnt <= LAT_W'(1));

endmodule

// File: rtl/sort_mem_responder.sv
// sort_mem_responder: memory-side responder for the sort engine's ar/r/aw/w/b
// bus. Holds a 2^ADDR_WDTH-word array, answers reads and writes after
// RD_LATENCY / WR_LATENCY wait cycles, one outstanding transaction per channel.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   ar_address/ar_valid/ar_ready   read address channel
//   r_data/r_resp/r_valid/r_ready  read data channel
//   aw_address/aw_valid/aw_ready   write address channel
//   w_data/w_valid/w_ready         write data channel
//   b_resp/b_valid/b_ready         write response channel
//   dbg_we/dbg_addr/dbg_wdata      backdoor write (bus commit wins on clash)
//   dbg_rdata                      combinational backdoor read of mem[dbg_addr]
// Build option: define MEM_RESPONDER_BOUNDS_CHECK_EN to make addresses
// >= MEM_LIMIT answer RESP_SLVERR (read returns 0, write dropped).
module sort_mem_responder
  import sort_mem_pkg::*;
#(
  parameter int ADDR_WDTH  = 4,
  parameter int DATA_WDTH  = 32,
  parameter int RESP_WDTH  = 1,
  parameter int RD_LATENCY = 0,
  parameter int WR_LATENCY = 0,
  parameter int MEM_LIMIT  = 2 ** ADDR_WDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_WDTH-1:0] ar_address,
  input  logic                 ar_valid,
  output logic                 ar_ready,
  output logic [DATA_WDTH-1:0] r_data,
  output logic [RESP_WDTH-1:0] r_resp,
  output logic                 r_valid,
  input  logic                 r_ready,
  input  logic [ADDR_WDTH-1:0] aw_address,
  input  logic                 aw_valid,
  output logic                 aw_ready,
  input  logic [DATA_WDTH-1:0] w_data,
  input  logic                 w_valid,
  output logic                 w_ready,
  output logic [RESP_WDTH-1:0] b_resp,
  output logic                 b_valid,
  input  logic                 b_ready,
  input  logic                 dbg_we,
  input  logic [ADDR_WDTH-1:0] dbg_addr,
  input  logic [DATA_WDTH-1:0] dbg_wdata,
  output logic [DATA_WDTH-1:0] dbg_rdata
);

  localparam int DEPTH = 2 ** ADDR_WDTH;
`ifdef MEM_RESPONDER_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif
  localparam logic [31:0]      LIMIT  = 32'(MEM_LIMIT);
  localparam logic [LAT_W-1:0] RD_LAT = LAT_W'(RD_LATENCY);
  localparam logic [LAT_W-1:0] WR_LAT = LAT_W'(WR_LATENCY);

  function automatic logic out_of_range(input logic [ADDR_WDTH-1:0] a);
    return BOUNDS_EN && (32'(a) >= LIMIT);
  endfunction

  function automatic logic [RESP_WDTH-1:0] resp_code(input logic err);
    return err ? RESP_WDTH'(RESP_SLVERR) : RESP_WDTH'(RESP_OKAY);
  endfunction

  logic [DATA_WDTH-1:0] mem [DEPTH];

  // ---------------- read channel ----------------
  rd_state_t rd_state, rd_next;
  logic      ar_fire, r_fire, rd_done, rd_oob;

  assign ar_fire = ar_valid && ar_ready;
  assign r_fire  = r_valid && r_ready;
  assign rd_oob  = out_of_range(ar_address);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_state <= R_IDLE;
    else     rd_state <= rd_next;
  end

  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      R_IDLE:  if (ar_fire) rd_next = (RD_LATENCY > 0) ? R_WAIT : R_RESP;
      R_WAIT:  if (rd_done) rd_next = R_RESP;
      R_RESP:  if (r_fire)  rd_next = R_IDLE;
      default: rd_next = R_IDLE;
    endcase
  end

  always_comb begin
    ar_ready = (rd_state == R_IDLE);
    r_valid  = (rd_state == R_RESP);
  end

  // Read data is captured at the handshake and held until the r handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
      r_resp <= '0;
    end else if (ar_fire) begin
      r_data <= rd_oob ? '0 : mem[ar_address];
      r_resp <= resp_code(rd_oob);
    end
  end

  resp_delay_ctr u_rd_ctr (
    .clk      (clk),
    .rst      (rst),
    .load     (ar_fire),
    .load_val (RD_LAT),
    .done     (rd_done)
  );

  // ---------------- write channel ----------------
  wr_state_t            wr_state, wr_next;
  logic                 aw_fire, w_fire, b_fire, wr_done;
  logic                 aw_got, w_got, commit, wr_oob, mem_we;
  logic [ADDR_WDTH-1:0] aw_addr_q, wr_addr;
  logic [DATA_WDTH-1:0] w_data_q, wr_wdata;

  assign aw_fire = aw_valid && aw_ready;
  assign w_fire  = w_valid && w_ready;
  assign b_fire  = b_valid && b_ready;

  // Commit on the edge the second half arrives; the half already held comes
  // from its capture register, the arriving half straight from the bus.
  assign commit   = (wr_state == W_IDLE) && (aw_got || aw_fire) && (w_got || w_fire);
  assign wr_addr  = aw_got ? aw_addr_q : aw_address;
  assign wr_wdata = w_got ? w_data_q : w_data;
  assign wr_oob   = out_of_range(wr_addr);
  assign mem_we   = commit && !wr_oob;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state <= W_IDLE;
      aw_got   <= 1'b0;
      w_got    <= 1'b0;
      b_resp   <= '0;
    end else begin
      wr_state <= wr_next;
      if (commit) begin
        aw_got <= 1'b0;
        w_got  <= 1'b0;
        b_resp <= resp_code(wr_oob);
      end else begin
        if (aw_fire) aw_got <= 1'b1;
        if (w_fire)  w_got  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (aw_fire) aw_addr_q <= aw_address;
    if (w_fire)  w_data_q  <= w_data;
  end

  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      W_IDLE:  if (commit)  wr_next = (WR_LATENCY > 0) ? W_WAIT : W_RESP;
      W_WAIT:  if (wr_done) wr_next = W_RESP;
      W_RESP:  if (b_fire)  wr_next = W_IDLE;
      default: wr_next = W_IDLE;
    endcase
  end

  always_comb begin
    aw_ready = (wr_state == W_IDLE) && !aw_got;
    w_ready  = (wr_state == W_IDLE) && !w_got;
    b_valid  = (wr_state == W_RESP);
  end

  resp_delay_ctr u_wr_ctr (
    .clk      (clk),
    .rst      (rst),
    .load     (commit),
    .load_val (WR_LAT),
    .done     (wr_done)
  );

  // ---------------- array ----------------
  // Bus write is last so it overrides a same-edge backdoor write.
  always_ff @(posedge clk) begin
    if (dbg_we) mem[dbg_addr] <= dbg_wdata;
    if (mem_we) mem[wr_addr]  <= wr_wdata;
  end

  assign dbg_rdata = mem[dbg_addr];

endmodule

// File: tb/tb_sort_mem_responder.sv
// tb_sort_mem_responder: directed bench for sort_mem_responder.
// dut_a: zero latency, default limit. dut_b: RD_LATENCY=3, WR_LATENCY=2,
// MEM_LIMIT=10. Bounds-check expectations follow MEM_RESPONDER_BOUNDS_CHECK_EN.
module tb_sort_mem_responder;
  localparam int AW = 4;
  localparam int DW = 32;
`ifdef MEM_RESPONDER_BOUNDS_CHECK_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [AW-1:0] a_ar_address, a_aw_address, a_dbg_addr;
  logic          a_ar_valid, a_ar_ready, a_r_valid, a_r_ready, a_aw_valid, a_aw_ready;
  logic          a_w_valid, a_w_ready, a_b_valid, a_b_ready, a_dbg_we;
  logic [DW-1:0] a_r_data, a_w_data, a_dbg_wdata, a_dbg_rdata;
  logic          a_r_resp, a_b_resp;

  logic [AW-1:0] b_ar_address, b_aw_address, b_dbg_addr;
  logic          b_ar_valid, b_ar_ready, b_r_valid, b_r_ready, b_aw_valid, b_aw_ready;
  logic          b_w_valid, b_w_ready, b_b_valid, b_b_ready, b_dbg_we;
  logic [DW-1:0] b_r_data, b_w_data, b_dbg_wdata, b_dbg_rdata;
  logic          b_r_resp, b_b_resp;

  int tests = 0;
  int fails = 0;

  sort_mem_responder #(.ADDR_WDTH(AW), .DATA_WDTH(DW), .RESP_WDTH(1),
                       .RD_LATENCY(0), .WR_LATENCY(0)) dut_a (
    .clk(clk), .rst(rst),
    .ar_address(a_ar_address), .ar_valid(a_ar_valid), .ar_ready(a_ar_ready),
    .r_data(a_r_data), .r_resp(a_r_resp), .r_valid(a_r_valid), .r_ready(a_r_ready),
    .aw_address(a_aw_address), .aw_valid(a_aw_valid), .aw_ready(a_aw_ready),
    .w_data(a_w_data), .w_valid(a_w_valid), .w_ready(a_w_ready),
    .b_resp(a_b_resp), .b_valid(a_b_valid), .b_ready(a_b_ready),
    .dbg_we(a_dbg_we), .dbg_addr(a_dbg_addr), .dbg_wdata(a_dbg_wdata), .dbg_rdata(a_dbg_rdata)
  );

  sort_mem_responder #(.ADDR_WDTH(AW), .DATA_WDTH(DW), .RESP_WDTH(1),
                       .RD_LATENCY(3), .WR_LATENCY(2), .MEM_LIMIT(10)) dut_b (
    .clk(clk), .rst(rst),
    .ar_address(b_ar_address), .ar_valid(b_ar_valid), .ar_ready(b_ar_ready),
    .r_data(b_r_data), .r_resp(b_r_resp), .r_valid(b_r_valid), .r_ready(b_r_ready),
    .aw_address(b_aw_address), .aw_valid(b_aw_valid), .aw_ready(b_aw_ready),
    .w_data(b_w_data), .w_valid(b_w_valid), .w_ready(b_w_ready),
    .b_resp(b_b_resp), .b_valid(b_b_valid), .b_ready(b_b_ready),
    .dbg_we(b_dbg_we), .dbg_addr(b_dbg_addr), .dbg_wdata(b_dbg_wdata), .dbg_rdata(b_dbg_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    a_ar_address = '0; a_aw_address = '0; a_dbg_addr = '0;
    a_ar_valid = 0; a_r_ready = 0; a_aw_valid = 0; a_w_valid = 0; a_b_ready = 0; a_dbg_we = 0;
    a_w_data = '0; a_dbg_wdata = '0;
    b_ar_address = '0; b_aw_address = '0; b_dbg_addr = '0;
    b_ar_valid = 0; b_r_ready = 0; b_aw_valid = 0; b_w_valid = 0; b_b_ready = 0; b_dbg_we = 0;
    b_w_data = '0; b_dbg_wdata = '0;
    tick(2);
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_ar_ready", a_ar_ready, 1);
    chk("rst_aw_ready", a_aw_ready, 1);
    chk("rst_w_ready",  a_w_ready, 1);
    chk("rst_r_valid",  a_r_valid, 0);
    chk("rst_b_valid",  a_b_valid, 0);
    chk("rst_r_data",   a_r_data, 0);
    chk("rst_r_resp",   a_r_resp, 0);
    chk("rst_b_resp",   a_b_resp, 0);
    chk("rst_b_rvalid", b_r_valid, 0);

    // Backdoor preload then zero-latency read of address 3
    a_dbg_we = 1; a_dbg_addr = 3; a_dbg_wdata = 32'hDEADBEEF;
    tick();
    a_dbg_we = 0;
    chk("dbg_rd3", a_dbg_rdata, 32'hDEADBEEF);
    a_ar_address = 3; a_ar_valid = 1;
    tick();
    a_ar_valid = 0;
    chk("rd3_valid", a_r_valid, 1);
    chk("rd3_data",  a_r_data, 32'hDEADBEEF);
    chk("rd3_resp",  a_r_resp, 0);
    chk("rd3_arrdy_low", a_ar_ready, 0);
    tick();
    chk("rd3_hold", a_r_valid, 1);
    a_r_ready = 1;
    tick();
    a_r_ready = 0;
    chk("rd3_done", a_r_valid, 0);
    chk("rd3_arrdy_back", a_ar_ready, 1);

    // aw two cycles ahead of w
    a_aw_address = 5; a_aw_valid = 1;
    tick();
    a_aw_valid = 0;
    chk("wr5_awrdy_low", a_aw_ready, 0);
    chk("wr5_wrdy_high", a_w_ready, 1);
    chk("wr5_no_b_yet",  a_b_valid, 0);
    tick();
    a_w_data = 32'h12345678; a_w_valid = 1;
    tick();
    a_w_valid = 0;
    chk("wr5_bvalid", a_b_valid, 1);
    chk("wr5_bresp",  a_b_resp, 0);
    chk("wr5_wrdy_low", a_w_ready, 0);
    a_dbg_addr = 5;
    #1;
    chk("wr5_dbg", a_dbg_rdata, 32'h12345678);
    a_b_ready = 1;
    tick();
    a_b_ready = 0;
    chk("wr5_bdone", a_b_valid, 0);
    chk("wr5_awrdy_back", a_aw_ready, 1);

    // Same-edge read and write commit to address 7: read sees old data
    a_dbg_we = 1; a_dbg_addr = 7; a_dbg_wdata = 32'h1;
    tick();
    a_dbg_we = 0;
    a_ar_address = 7; a_ar_valid = 1;
    a_aw_address = 7; a_aw_valid = 1; a_w_data = 32'h2; a_w_valid = 1;
    tick();
    a_ar_valid = 0; a_aw_valid = 0; a_w_valid = 0;
    chk("same7_rdata_old", a_r_data, 32'h1);
    chk("same7_bvalid", a_b_valid, 1);
    a_r_ready = 1; a_b_ready = 1;
    tick();
    a_r_ready = 0; a_b_ready = 0;
    a_ar_address = 7; a_ar_valid = 1;
    tick();
    a_ar_valid = 0;
    chk("same7_rdata_new", a_r_data, 32'h2);
    a_r_ready = 1;
    tick();
    a_r_ready = 0;

    // w before aw; aw commit coincides with a backdoor write to the same word
    a_w_data = 32'h66; a_w_valid = 1;
    tick();
    a_w_valid = 0;
    chk("w6_wrdy_low", a_w_ready, 0);
    chk("w6_no_b", a_b_valid, 0);
    chk("w6_awrdy", a_aw_ready, 1);
    a_aw_address = 6; a_aw_valid = 1;
    a_dbg_we = 1; a_dbg_addr = 6; a_dbg_wdata = 32'hAAAA;
    tick();
    a_aw_valid = 0; a_dbg_we = 0;
    chk("w6_bvalid", a_b_valid, 1);
    chk("w6_bus_wins", a_dbg_rdata, 32'h66);
    a_b_ready = 1;
    tick();
    a_b_ready = 0;

    // dut_b latencies: read and write accepted on the same edge T
    b_dbg_we = 1; b_dbg_addr = 2; b_dbg_wdata = 32'hCAFE;
    tick();
    b_dbg_we = 0;
    b_ar_address = 2; b_ar_valid = 1;
    b_aw_address = 4; b_aw_valid = 1; b_w_data = 32'h44; b_w_valid = 1;
    tick();
    b_ar_valid = 0; b_aw_valid = 0; b_w_valid = 0;
    chk("lat_T1_rv", b_r_valid, 0);
    chk("lat_T1_bv", b_b_valid, 0);
    chk("lat_T1_arrdy", b_ar_ready, 0);
    tick();
    chk("lat_T2_rv", b_r_valid, 0);
    chk("lat_T2_bv", b_b_valid, 0);
    tick();
    chk("lat_T3_rv", b_r_valid, 0);
    chk("lat_T3_bv", b_b_valid, 1);
    chk("lat_T3_bresp", b_b_resp, 0);
    tick();
    chk("lat_T4_rv", b_r_valid, 1);
    chk("lat_T4_rdata", b_r_data, 32'hCAFE);
    chk("lat_T4_bv", b_b_valid, 1);
    tick();
    chk("lat_T5_rv", b_r_valid, 1);
    chk("lat_T5_rdata", b_r_data, 32'hCAFE);
    chk("lat_T5_bv", b_b_valid, 1);
    b_r_ready = 1; b_b_ready = 1;
    tick();
    b_r_ready = 0; b_b_ready = 0;
    chk("lat_done_rv", b_r_valid, 0);
    chk("lat_done_bv", b_b_valid, 0);
    b_dbg_addr = 4;
    #1;
    chk("lat_dbg4", b_dbg_rdata, 32'h44);

    // Bounds: MEM_LIMIT=10, addresses 12 (read) and 11 (write)
    b_dbg_we = 1; b_dbg_addr = 12; b_dbg_wdata = 32'h1212;
    tick();
    b_dbg_addr = 11; b_dbg_wdata = 32'h1111;
    tick();
    b_dbg_we = 0;
    b_ar_address = 12; b_ar_valid = 1;
    tick();
    b_ar_valid = 0;
    tick(3);
    chk("oob_rd_valid", b_r_valid, 1);
    chk("oob_rd_resp", b_r_resp, BC);
    chk("oob_rd_data", b_r_data, BC ? 32'h0 : 32'h1212);
    b_r_ready = 1;
    tick();
    b_r_ready = 0;
    b_aw_address = 11; b_aw_valid = 1; b_w_data = 32'h77; b_w_valid = 1;
    tick();
    b_aw_valid = 0; b_w_valid = 0;
    tick(2);
    chk("oob_wr_valid", b_b_valid, 1);
    chk("oob_wr_resp", b_b_resp, BC);
    b_dbg_addr = 11;
    #1;
    chk("oob_wr_mem", b_dbg_rdata, BC ? 32'h1111 : 32'h77);
    b_b_ready = 1;
    tick();
    b_b_ready = 0;

    // Reset while r_valid is pending; array contents survive
    b_ar_address = 4; b_ar_valid = 1;
    tick();
    b_ar_valid = 0;
    tick(3);
    chk("prerst_rv", b_r_valid, 1);
    #1;
    rst = 1'b1;
    #1;
    chk("inrst_rv", b_r_valid, 0);
    rst = 1'b0;
    tick();
    chk("postrst_rv", b_r_valid, 0);
    chk("postrst_arrdy", b_ar_ready, 1);
    b_ar_address = 4; b_ar_valid = 1;
    tick();
    b_ar_valid = 0;
    tick(3);
    chk("postrst_rd_valid", b_r_valid, 1);
    chk("postrst_rd_data", b_r_data, 32'h44);
    b_r_ready = 1;
    tick();
    b_r_ready = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sort_mem_responder.md
# sort_mem_responder

Memory-side responder for the sort engine's five-channel bus (ar/r read, aw/w/b write). It holds a 2^ADDR_WDTH-word array and answers read-address and write-address/data requests with data and response codes after programmable latencies. It sits opposite `sort_circuit` in benches and integration tops, and has a backdoor port for preloading and checking array contents.

## Interface
- ADDR_WDTH, 4, address width; array depth = 2^ADDR_WDTH words
- DATA_WDTH, 32, data word width
- RESP_WDTH, 1, response code width
- RD_LATENCY, 0, extra wait cycles before r_valid (0..255)
- WR_LATENCY, 0, extra wait cycles before b_valid (0..255)
- MEM_LIMIT, 2^ADDR_WDTH, first out-of-range word address (bounds check only)
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  asynchronous, active-high reset
- ar_address  in  ADDR_WDTH  read address
- ar_valid  in  1  read address valid
- ar_ready  out  1  read address accepted
- r_data  out  DATA_WDTH  read data
- r_resp  out  RESP_WDTH  read response
- r_valid  out  1  read data valid
- r_ready  in  1  initiator accepts read data
- aw_address  in  ADDR_WDTH  write address
- aw_valid  in  1  write address valid
- aw_ready  out  1  write address accepted
- w_data  in  DATA_WDTH  write data
- w_valid  in  1  write data valid
- w_ready  out  1  write data accepted
- b_resp  out  RESP_WDTH  write response
- b_valid  out  1  write response valid
- b_ready  in  1  initiator accepts write response
- dbg_we  in  1  backdoor write enable
- dbg_addr  in  ADDR_WDTH  backdoor address
- dbg_wdata  in  DATA_WDTH  backdoor write data
- dbg_rdata  out  DATA_WDTH  combinational backdoor read of mem[dbg_addr]

## Operation
- Reset: ar_ready=1, aw_ready=1, w_ready=1, r_valid=0, b_valid=0, r_data=0, r_resp=0, b_resp=0. Array contents are not reset.
- Read FSM: R_IDLE -> R_WAIT -> R_RESP -> R_IDLE.
  - R_IDLE: ar_ready=1. On ar_valid&&ar_ready, latch mem[ar_address] into r_data and the response into r_resp. Go to R_WAIT if RD_LATENCY>0, else R_RESP.
  - R_WAIT: counts RD_LATENCY cycles; ar_ready=0.
  - R_RESP: r_valid=1; r_data and r_resp held stable until r_valid&&r_ready, then R_IDLE.
- Write FSM: W_IDLE -> W_WAIT -> W_RESP -> W_IDLE.
  - W_IDLE: aw and w are captured independently, in any order or together. After capture, each ready drops until the transaction ends.
  - Commit writes mem[addr]=data on the edge where the second of the two is captured (the same edge if both are captured together).
  - W_WAIT counts WR_LATENCY cycles. W_RESP holds b_valid=1 until b_ready.
- Read and write channels are fully independent; one outstanding transaction per channel.
- Same-edge read latch and write commit to the same address: the read returns the old data.
- Backdoor write on the same edge as a bus commit to the same address: the bus data wins.
- rst asserted mid-transaction: outstanding transactions are abandoned and no r_valid/b_valid is issued. Array contents are retained.

## Timing
- ar handshake at edge T: r_valid high from T+1+RD_LATENCY.
- Write commit at edge T: b_valid high from T+1+WR_LATENCY.
- r_valid and b_valid are never deasserted without their ready. ar_ready is low while a read is outstanding.
- Back-to-back reads: the next ar can be accepted one cycle after the r handshake (ar_ready rises the cycle after).
- dbg_rdata: zero-cycle combinational read; it reflects a commit from the following cycle onward.

## Configuration
- MEM_RESPONDER_BOUNDS_CHECK_EN defined: an address >= MEM_LIMIT gives r_resp/b_resp = RESP_SLVERR (1). The read returns 0 and the write is dropped (b is still issued).
- Not defined: MEM_LIMIT is ignored, every address decodes, and all responses are RESP_OKAY (0).

## Structure
- Package `sort_mem_pkg`: RESP_OKAY=0, RESP_SLVERR=1, read/write FSM state encodings, latency counter width (8).
- One sub-module, `resp_delay_ctr`: load/decrement counter with a done flag, instantiated once per channel.

## Test plan
- Backdoor preload mem[3]=0xDEADBEEF; ar_address=3 with RD_LATENCY=0 -> r_valid one cycle after handshake, r_data=0xDEADBEEF, r_resp=0.
- aw_address=5 two cycles before w_data=0x12345678 -> b_valid one cycle after the w handshake; dbg_rdata at address 5 = 0x12345678.
- RD_LATENCY=3, WR_LATENCY=2, r_ready/b_ready held low 4 cycles -> valids rise at T+4 and T+3 respectively and hold with stable data until ready.
- Same-edge read of address 7 (old 0x1) and write commit 0x2 to address 7 -> r_data=0x1; a later read returns 0x2.
- With MEM_RESPONDER_BOUNDS_CHECK_EN and MEM_LIMIT=10: read address 12 -> r_resp=1, r_data=0; write address 11 -> b_resp=1, array unchanged.
- rst pulsed while r_valid is pending -> r_valid=0, ar_ready=1 after reset; previously written data is still readable.
